pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage integer pipeline. Drives the stall/flush enables of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the forwarding selects of the EX and ID operand muxes. Owns the data-memory request/acknowledge handshake, freezing the pipeline while a MEM-stage access is outstanding. Keeps a saturating stall-cycle counter for performance measurement.

## Interface
- TIMEOUT, 64: max cycles in WAIT before abort; 0 disables timeout
- CNT_W, 16: width of stall counter
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rsD, rtD  in  5  source registers of instruction in ID
- rsE, rtE  in  5  source registers of instruction in EX
- writeRegE, writeRegM, writeRegW  in  5  destination register per stage
- regWriteE, regWriteM, regWriteW  in  1  register-file write enable per stage
- memToRegE  in  1  EX instruction is a load
- branchD  in  1  ID instruction is a branch (compares in ID)
- memReqM  in  1  MEM instruction accesses data memory
- dmem_ack  in  1  data memory completes access this cycle
- dmem_req  out  1  data-memory request
- stallF, stallD, stallE, stallM  out  1  hold PC / IF-ID / ID-EX / EX-MEM
- flushE, flushW  out  1  insert bubble into ID-EX / MEM-WB
- forwardAE, forwardBE  out  2  EX operand select: 00 regfile, 01 WB result, 10 MEM aluOut
- forwardAD, forwardBD  out  1  ID branch operand from MEM aluOut
- mem_err  out  1  sticky: a memory access timed out
- stall_cnt  out  CNT_W  saturating count of cycles with stallF=1

## Operation
- Register 0 never matches for forwarding or hazards (writeReg==0 ignored).
- forwardAE: 10 if regWriteM & writeRegM==rsE; else 01 if regWriteW & writeRegW==rsE; else 00. MEM beats WB. Same for BE with rtE.
- forwardAD = regWriteM & writeRegM==rsD; BD with rtD.
- lwstall = memToRegE & regWriteE & writeRegE in {rsD, rtD}.
- brstall = branchD & ((regWriteE & writeRegE in {rsD,rtD}) | (memToRegM & writeRegM in {rsD,rtD})).
- FSM states RUN, WAIT. RUN: dmem_req=memReqM; memReqM & !dmem_ack -> WAIT. WAIT: dmem_req=1; dmem_ack -> RUN; timeout -> RUN, set mem_err.
- memstall = (RUN & memReqM & !dmem_ack) | (WAIT & !dmem_ack & !timeout_hit).
- stallF = stallD = lwstall | brstall | memstall; stallE = stallM = memstall; flushW = memstall.
- flushE = (lwstall | brstall) & !memstall (memory stall wins; ID-EX frozen, not flushed).
- wait counter: cleared on entry to WAIT, increments each WAIT cycle; timeout_hit when count == TIMEOUT-1 and TIMEOUT!=0 and !dmem_ack.
- stall_cnt increments when stallF=1, saturates at all-ones.

## Timing
- All stall/flush/forward/dmem_req outputs combinational from inputs and state; zero latency.
- State, wait counter, mem_err, stall_cnt update on rising clk.
- Reset (async, any time incl. mid-WAIT): state=RUN, wait counter=0, mem_err=0, stall_cnt=0; combinational outputs follow inputs in RUN immediately.
- Ack in first request cycle: no stall. Ack in WAIT cycle n: stalls drop that cycle, pipeline advances on next edge; total stall = n cycles.
- Timeout: abort cycle has memstall=0; access dropped; mem_err stays 1 until reset.
- dmem_ack while dmem_req=0: ignored.

## Structure
- Shared package: FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10; state encoding RUN=1'b0, WAIT=1'b1; register-address width constant.
- One sub-module: hazard_fwd_unit (purely combinational forwarding and lwstall/brstall); FSM and counters in top.

## Test plan
- EX rsE=3, regWriteM=1, writeRegM=3, regWriteW=1, writeRegW=3 -> forwardAE=10; with regWriteM=0 -> 01; writeRegM=0, rsE=0 -> 00.
- Load in EX writeRegE=5, rtD=5 -> stallF=stallD=flushE=1 for one cycle, stall_cnt 0->1.
- memReqM=1, dmem_ack after 3 cycles -> dmem_req high 4 cycles, stallF..stallM & flushW high 3 cycles, state returns RUN, stall_cnt=3.
- Load-use coincident with memory wait -> flushE=0, stallE=1 throughout; after ack, flushE=1 for one cycle.
- TIMEOUT=4, no ack -> abort on 4th WAIT cycle, mem_err=1 sticky, memstall=0 that cycle.
- Assert rst in WAIT cycle 2 -> state RUN, mem_err=0, stall_cnt=0 without a clock edge.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard/sequencing controller.
// Holds the forwarding select codes, the FSM encoding and the register-match helper.
package pipe_hazard_ctrl_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Register 0 is hardwired, so a write to it never creates a dependency.
    function automatic logic regHit(input logic we,
                                    input logic [REG_W-1:0] dst,
                                    input logic [REG_W-1:0] src);
        return we && (dst != '0) && (dst == src);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_fwd_unit.sv
// Combinational operand forwarding selects and load-use / branch hazard detection.
// Holds no state; the top module combines these results with the memory stall.
module hazard_fwd_unit
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] rsD,
    input  logic [REG_W-1:0] rtD,
    input  logic [REG_W-1:0] rsE,
    input  logic [REG_W-1:0] rtE,
    input  logic [REG_W-1:0] writeRegE,
    input  logic [REG_W-1:0] writeRegM,
    input  logic [REG_W-1:0] writeRegW,
    input  logic             regWriteE,
    input  logic             regWriteM,
    input  logic             regWriteW,
    input  logic             memToRegE,
    input  logic             memToRegM,
    input  logic             branchD,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             forwardAD,
    output logic             forwardBD,
    output logic             lwStall,
    output logic             brStall
);

    logic exHitD;
    logic memLoadHitD;

    always_comb begin
        forwardAE = FWD_REG;
        forwardBE = FWD_REG;
        // MEM holds the younger result, so it wins over WB.
        if (regHit(regWriteM, writeRegM, rsE))      forwardAE = FWD_MEM;
        else if (regHit(regWriteW, writeRegW, rsE)) forwardAE = FWD_WB;
        if (regHit(regWriteM, writeRegM, rtE))      forwardBE = FWD_MEM;
        else if (regHit(regWriteW, writeRegW, rtE)) forwardBE = FWD_WB;

        forwardAD = regHit(regWriteM, writeRegM, rsD);
        forwardBD = regHit(regWriteM, writeRegM, rtD);

        exHitD      = regHit(regWriteE, writeRegE, rsD) || regHit(regWriteE, writeRegE, rtD);
        memLoadHitD = regHit(memToRegM, writeRegM, rsD) || regHit(memToRegM, writeRegM, rtD);

        lwStall = memToRegE && exHitD;
        brStall = branchD && (exHitD || memLoadHitD);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard and sequencing controller: stall/flush enables, forwarding selects,
// data-memory handshake FSM with timeout, and a saturating stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rsD,
    input  logic [REG_W-1:0] rtD,
    input  logic [REG_W-1:0] rsE,
    input  logic [REG_W-1:0] rtE,
    input  logic [REG_W-1:0] writeRegE,
    input  logic [REG_W-1:0] writeRegM,
    input  logic [REG_W-1:0] writeRegW,
    input  logic             regWriteE,
    input  logic             regWriteM,
    input  logic             regWriteW,
    input  logic             memToRegE,
    input  logic             branchD,
    input  logic             memReqM,
    input  logic             dmem_ack,
    output logic             dmem_req,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushE,
    output logic             flushW,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             forwardAD,
    output logic             forwardBD,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT == 0) ? '0 : WAIT_W'(TIMEOUT - 1);

    state_t            state;
    logic [WAIT_W-1:0] waitCnt;
    logic              memToRegM;
    logic              lwStall;
    logic              brStall;
    logic              timeoutHit;
    logic              memStall;

    hazard_fwd_unit uHazard (
        .rsD       (rsD),
        .rtD       (rtD),
        .rsE       (rsE),
        .rtE       (rtE),
        .writeRegE (writeRegE),
        .writeRegM (writeRegM),
        .writeRegW (writeRegW),
        .regWriteE (regWriteE),
        .regWriteM (regWriteM),
        .regWriteW (regWriteW),
        .memToRegE (memToRegE),
        .memToRegM (memToRegM),
        .branchD   (branchD),
        .forwardAE (forwardAE),
        .forwardBE (forwardBE),
        .forwardAD (forwardAD),
        .forwardBD (forwardBD),
        .lwStall   (lwStall),
        .brStall   (brStall)
    );

    always_comb begin
        timeoutHit = (TIMEOUT != 0) && (state == WAIT) && (waitCnt == WAIT_LAST) && !dmem_ack;
        memStall   = ((state == RUN) && memReqM && !dmem_ack) ||
                     ((state == WAIT) && !dmem_ack && !timeoutHit);
        dmem_req   = (state == WAIT) ? 1'b1 : memReqM;
        stallF     = lwStall || brStall || memStall;
        stallD     = stallF;
        stallE     = memStall;
        stallM     = memStall;
        flushW     = memStall;
        // A frozen ID-EX register must keep its instruction, so the memory stall wins.
        flushE     = (lwStall || brStall) && !memStall;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            waitCnt   <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            memToRegM <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (memReqM && !dmem_ack) begin
                        state   <= WAIT;
                        waitCnt <= '0;
                    end
                end
                WAIT: begin
                    if (dmem_ack) begin
                        state <= RUN;
                    end else if (timeoutHit) begin
                        state   <= RUN;
                        mem_err <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                default: state <= RUN;
            endcase

            if (stallF && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;

            // Local copy of the EX-MEM load flag, advancing with the EX-MEM register.
            if (!stallM) memToRegM <= memToRegE;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding/hazard vector table plus
// hand-written memory wait, timeout, reset and counter-saturation sequences.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
    logic       regWriteE, regWriteM, regWriteW, memToRegE, branchD, memReqM, dmem_ack;
    logic       dmem_req, stallF, stallD, stallE, stallM, flushE, flushW;
    logic [1:0] forwardAE, forwardBE;
    logic       forwardAD, forwardBD, mem_err;
    logic [3:0] stall_cnt;

    int checks = 0;
    int failures = 0;

    pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
        .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
        .memToRegE(memToRegE), .branchD(branchD), .memReqM(memReqM), .dmem_ack(dmem_ack),
        .dmem_req(dmem_req), .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushE(flushE), .flushW(flushW), .forwardAE(forwardAE), .forwardBE(forwardBE),
        .forwardAD(forwardAD), .forwardBD(forwardBD), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW;
        logic       rwE, rwM, rwW, mtrE, prevLoad, br;
        logic [1:0] fAE, fBE;
        logic       fAD, fBD, stall, flush;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(int a_rsD, int a_rtD, int a_rsE, int a_rtE,
                                int a_wE, int a_wM, int a_wW,
                                int a_rwE, int a_rwM, int a_rwW, int a_mtrE, int a_prev, int a_br,
                                int e_fAE, int e_fBE, int e_fAD, int e_fBD, int e_stall, int e_flush);
        vec_t v;
        v.rsD = 5'(a_rsD); v.rtD = 5'(a_rtD); v.rsE = 5'(a_rsE); v.rtE = 5'(a_rtE);
        v.wE = 5'(a_wE); v.wM = 5'(a_wM); v.wW = 5'(a_wW);
        v.rwE = 1'(a_rwE); v.rwM = 1'(a_rwM); v.rwW = 1'(a_rwW);
        v.mtrE = 1'(a_mtrE); v.prevLoad = 1'(a_prev); v.br = 1'(a_br);
        v.fAE = 2'(e_fAE); v.fBE = 2'(e_fBE); v.fAD = 1'(e_fAD); v.fBD = 1'(e_fBD);
        v.stall = 1'(e_stall); v.flush = 1'(e_flush);
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic clr();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0; writeRegE = 0; writeRegM = 0; writeRegW = 0;
        regWriteE = 0; regWriteM = 0; regWriteW = 0; memToRegE = 0; branchD = 0;
        memReqM = 0; dmem_ack = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        tick();
    endtask

    task automatic driveLoadUse();
        memToRegE = 1; regWriteE = 1; writeRegE = 5; rtD = 5;
    endtask

    task automatic chkMemStall(input string nm, input int exp);
        chk({nm, ".stallF"}, stallF, exp);
        chk({nm, ".stallD"}, stallD, exp);
        chk({nm, ".stallE"}, stallE, exp);
        chk({nm, ".stallM"}, stallM, exp);
        chk({nm, ".flushW"}, flushW, exp);
    endtask

    initial begin
        clr();
        rst = 1'b1;
        #1;
        chk("reset.stall_cnt", stall_cnt, 0);
        chk("reset.mem_err", mem_err, 0);
        chk("reset.dmem_req", dmem_req, 0);
        chk("reset.stallF", stallF, 0);
        memReqM = 1;
        #1;
        chk("reset.dmem_req_follows", dmem_req, 1);
        chk("reset.stallE_follows", stallE, 1);
        memReqM = 0;
        @(negedge clk);
        rst = 1'b0;
        tick();

        // rsD rtD rsE rtE wE wM wW rwE rwM rwW mtrE prev br | fAE fBE fAD fBD stall flush
        add(0, 0, 3, 0, 0, 3, 3, 0, 1, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0);
        add(0, 0, 3, 0, 0, 3, 3, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 7, 0, 2, 7, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 9, 0, 9, 9, 0, 1, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0);
        add(4, 4, 0, 0, 0, 4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        add(4, 4, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 5, 0, 0, 5, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 5, 0, 0, 5, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(6, 0, 0, 0, 6, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(6, 0, 0, 0, 6, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1);
        add(0, 8, 0, 0, 0, 8, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 1, 1, 1);
        add(0, 8, 0, 0, 0, 8, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            // Set up the load flag that moves into MEM on the next edge.
            clr();
            memToRegE = vecs[i].prevLoad;
            tick();
            rsD = vecs[i].rsD; rtD = vecs[i].rtD; rsE = vecs[i].rsE; rtE = vecs[i].rtE;
            writeRegE = vecs[i].wE; writeRegM = vecs[i].wM; writeRegW = vecs[i].wW;
            regWriteE = vecs[i].rwE; regWriteM = vecs[i].rwM; regWriteW = vecs[i].rwW;
            memToRegE = vecs[i].mtrE; branchD = vecs[i].br;
            #1;
            chk($sformatf("vec%0d.forwardAE", i), forwardAE, vecs[i].fAE);
            chk($sformatf("vec%0d.forwardBE", i), forwardBE, vecs[i].fBE);
            chk($sformatf("vec%0d.forwardAD", i), forwardAD, vecs[i].fAD);
            chk($sformatf("vec%0d.forwardBD", i), forwardBD, vecs[i].fBD);
            chk($sformatf("vec%0d.stallF", i), stallF, vecs[i].stall);
            chk($sformatf("vec%0d.stallD", i), stallD, vecs[i].stall);
            chk($sformatf("vec%0d.flushE", i), flushE, vecs[i].flush);
            chk($sformatf("vec%0d.stallE", i), stallE, 0);
            tick();
        end

        // Single-cycle load-use stall
        clr();
        pulseReset();
        driveLoadUse();
        #1;
        chk("lw.stallF", stallF, 1);
        chk("lw.flushE", flushE, 1);
        chk("lw.stallE", stallE, 0);
        chk("lw.cnt_before", stall_cnt, 0);
        tick();
        clr();
        #1;
        chk("lw.stallF_after", stallF, 0);
        chk("lw.cnt_after", stall_cnt, 1);
        tick();

        // Memory access acked in the 3rd WAIT cycle
        pulseReset();
        for (int c = 0; c < 4; c++) begin
            memReqM = 1;
            dmem_ack = (c == 3);
            #1;
            chk($sformatf("ack.c%0d.dmem_req", c), dmem_req, 1);
            chkMemStall($sformatf("ack.c%0d", c), (c < 3) ? 1 : 0);
            tick();
        end
        clr();
        #1;
        chk("ack.back_to_run", dmem_req, 0);
        chk("ack.stall_cnt", stall_cnt, 3);
        tick();

        // Load-use hazard coincident with a memory wait
        pulseReset();
        for (int c = 0; c < 3; c++) begin
            memReqM = 1;
            driveLoadUse();
            dmem_ack = (c == 2);
            #1;
            chk($sformatf("co.c%0d.flushE", c), flushE, (c == 2) ? 1 : 0);
            chk($sformatf("co.c%0d.stallE", c), stallE, (c == 2) ? 0 : 1);
            chk($sformatf("co.c%0d.stallF", c), stallF, 1);
            tick();
        end
        clr();
        #1;
        chk("co.flushE_after", flushE, 0);
        chk("co.stall_cnt", stall_cnt, 3);
        tick();

        // Timeout: no ack, abort on the 4th WAIT cycle
        pulseReset();
        for (int c = 0; c < 5; c++) begin
            memReqM = 1;
            #1;
            chk($sformatf("to.c%0d.dmem_req", c), dmem_req, 1);
            chkMemStall($sformatf("to.c%0d", c), (c < 4) ? 1 : 0);
            chk($sformatf("to.c%0d.mem_err", c), mem_err, 0);
            tick();
        end
        clr();
        #1;
        chk("to.dmem_req_after", dmem_req, 0);
        chk("to.mem_err", mem_err, 1);
        chk("to.stall_cnt", stall_cnt, 4);
        dmem_ack = 1;
        #1;
        chk("stray_ack.dmem_req", dmem_req, 0);
        chk("stray_ack.stallF", stallF, 0);
        tick();
        dmem_ack = 0;
        #1;
        chk("stray_ack.still_run", dmem_req, 0);
        chk("to.mem_err_sticky", mem_err, 1);
        chk("stray_ack.stall_cnt", stall_cnt, 4);

        // Async reset in WAIT cycle 2
        memReqM = 1;
        tick();
        tick();
        #1;
        chk("rstwait.dmem_req", dmem_req, 1);
        chk("rstwait.stall_cnt", stall_cnt, 6);
        memReqM = 0;
        #1;
        chk("rstwait.in_wait", dmem_req, 1);
        rst = 1'b1;
        #1;
        chk("rstwait.dmem_req_run", dmem_req, 0);
        chk("rstwait.stallF", stallF, 0);
        chk("rstwait.mem_err", mem_err, 0);
        chk("rstwait.stall_cnt", stall_cnt, 0);
        rst = 1'b0;
        tick();

        // Stall counter saturation
        clr();
        pulseReset();
        driveLoadUse();
        for (int i = 0; i < 15; i++) tick();
        #1;
        chk("sat.cnt15", stall_cnt, 15);
        for (int i = 0; i < 5; i++) tick();
        #1;
        chk("sat.held", stall_cnt, 15);
        clr();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
